// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM: counting modes and counter direction.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Common PWM timebase: prescaler, sawtooth/triangle period counter, tick and period-boundary strobes.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 mode_i,
    input  logic [PRE_WIDTH-1:0] prescale_i,
    input  logic [WIDTH-1:0]     period_i,
    output logic [WIDTH-1:0]     count_o,
    output logic                 tick_o,
    output logic                 boundary_o
);

    logic [PRE_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    dir_e                 dir_q, dir_d;
    logic                 tick;
    logic                 boundary;

    // A boundary is the tick on which the counter returns to 0 and a new period begins.
    always_comb begin
        tick     = (pcnt_q == prescale_i);
        pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (tick) begin
            if (mode_i == MODE_EDGE) begin
                dir_d = DIR_UP;
                if (cnt_q == period_i) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (period_i == '0) begin
                cnt_d    = '0;
                dir_d    = DIR_UP;
                boundary = 1'b1;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == period_i) begin
                    cnt_d = cnt_q - 1'b1;
                    // With P = 1 the turn-around step already lands on 0.
                    if (cnt_q == WIDTH'(1)) begin
                        boundary = 1'b1;
                    end else begin
                        dir_d = DIR_DOWN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == WIDTH'(1)) begin
                    dir_d    = DIR_UP;
                    boundary = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en_i) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

    assign count_o    = cnt_q;
    assign tick_o     = en_i & tick;
    assign boundary_o = en_i & boundary;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shadowed period/prescale/mode/duty and a period sync pulse.
// Optional per-channel output polarity is enabled with PWM_POLARITY_EN.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int PRE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [PRE_WIDTH-1:0]      prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0]       pol,
`endif
    output logic [CHANNELS-1:0]       out,
    output logic                      sync
);

    logic                      modeSh_q;
    logic [PRE_WIDTH-1:0]      prescaleSh_q;
    logic [WIDTH-1:0]          periodSh_q;
    logic [CHANNELS*WIDTH-1:0] dutySh_q;
    logic                      first_q;
    logic                      sync_q;
    logic [WIDTH-1:0]          count;
    logic                      tick;
    logic                      boundary;
    logic                      periodEnd;
    logic                      loadShadow;
    logic [CHANNELS-1:0]       polRun;
    logic [CHANNELS-1:0]       polIdle;

    pwm_timebase #(
        .WIDTH     (WIDTH),
        .PRE_WIDTH (PRE_WIDTH)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .mode_i     (modeSh_q),
        .prescale_i (prescaleSh_q),
        .period_i   (periodSh_q),
        .count_o    (count),
        .tick_o     (tick),
        .boundary_o (boundary)
    );

    assign periodEnd  = tick & boundary;
    assign loadShadow = !en || periodEnd;

    // Shadows are transparent while disabled and otherwise only follow the inputs at a period boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            modeSh_q     <= MODE_EDGE;
            prescaleSh_q <= '0;
            periodSh_q   <= '0;
            dutySh_q     <= '0;
        end else if (loadShadow) begin
            modeSh_q     <= mode;
            prescaleSh_q <= prescale;
            periodSh_q   <= period;
            dutySh_q     <= duty;
        end
    end

`ifdef PWM_POLARITY_EN
    logic [CHANNELS-1:0] polSh_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            polSh_q <= '0;
        end else if (loadShadow) begin
            polSh_q <= pol;
        end
    end

    assign polRun  = polSh_q;
    assign polIdle = pol;
`else
    assign polRun  = '0;
    assign polIdle = '0;
`endif

    // first_q marks the first clk of the counter-0 state, including the first period after enable or reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_q <= 1'b1;
            sync_q  <= 1'b0;
        end else begin
            first_q <= !en || periodEnd;
            sync_q  <= en && first_q;
        end
    end

    assign sync = sync_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic chan_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                chan_q <= 1'b0;
            end else if (!en) begin
                chan_q <= polIdle[i];
            end else begin
                chan_q <= (dutySh_q[i*WIDTH +: WIDTH] > count) ^ polRun[i];
            end
        end

        assign out[i] = chan_q;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel PWM generator. All channels share one timebase: a prescaler and a period counter.
- Supports edge-aligned (sawtooth) and center-aligned (triangle) counting.
- Period, prescale, mode and duty are shadowed and update only at period boundaries, so outputs never glitch.
- Drives motor/LED/servo outputs. The sync pulse lets ADC sampling or peer blocks lock to the period.

Parameters:
- WIDTH, 8: counter, period and duty width.
- CHANNELS, 4: number of independent PWM outputs.
- PRE_WIDTH, 8: prescaler width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  run enable.
- mode  input  1  0 = edge-aligned, 1 = center-aligned.
- prescale  input  PRE_WIDTH  timebase ticks once every prescale+1 clk cycles.
- period  input  WIDTH  terminal count P.
- duty  input  CHANNELS*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH].
- out  output  CHANNELS  PWM outputs, registered.
- sync  output  1  one-clk pulse at the start of each period, registered.

Behaviour:
- Reset (rst_n low at posedge):
  - Prescaler count, period counter and all shadows cleared to 0.
  - Direction set to up.
  - out = 0, sync = 0.
  - Reset takes priority over en and over any boundary event.
  - A reset mid-period aborts the period immediately; no partial pulse is completed.
- en low:
  - Prescaler count and counter held at 0; direction set to up.
  - out = 0, sync = 0.
  - Shadows load from the inputs every cycle (transparent).
- en rising: the first period starts from counter 0 using the values captured in the last disabled cycle.
- Prescaler:
  - pcnt counts 0..prescale_sh.
  - tick is asserted when pcnt == prescale_sh, and pcnt wraps to 0 on that tick.
  - prescale = 0 gives a tick every clk.
- Edge mode:
  - On each tick the counter goes 0,1,..,P then wraps to 0.
  - Period = P+1 ticks.
- Center mode:
  - On each tick the counter goes 0,1,..,P, then P-1,..,1, then back to 0.
  - Period = 2P ticks.
  - P = 0: counter stays at 0 and period = 1 tick.
- Boundary: the tick on which the counter becomes 0.
  - Edge mode: the tick that wraps from P.
  - Center mode: the tick that steps from 1 down to 0.
  - On the boundary tick, shadows (mode, prescale, period, duty) load the input values present in that same cycle.
  - Input changes at any other time are ignored until the next boundary.
  - A prescale change takes effect from the next tick after the boundary.
- Compare:
  - Unsigned compare, out_next[i] = duty_sh[i] > counter.
  - out is registered, so it lags the counter by 1 clk.
  - duty = 0 gives constant low.
  - duty > P gives constant high with no gap at wrap.
  - Center-mode high time = 2*duty-1 ticks when 1 <= duty <= P, symmetric about counter 0.
- sync:
  - Asserted 1 clk, registered with the same lag as out, on the first clk of the counter = 0 state of each period.
  - Also asserted for the first period after enable.
- Counter arithmetic is WIDTH bits and never exceeds P.
- A period value lowered below the current count cannot be reached mid-period, because it is shadowed.

Optional Feature:
- Macro: PWM_POLARITY_EN.
- Defined:
  - Adds input pol [CHANNELS-1:0], shadowed like duty.
  - out[i] = compare XOR pol_sh[i].
  - Idle and reset output level for channel i = pol input value (pol_sh during run).
  - Reset output level is 0, because shadows clear to 0.
- Undefined: no pol port; outputs are active-high, as specified above.

Decomposition:
- Package pwm_pkg:
  - mode constants MODE_EDGE = 1'b0, MODE_CENTER = 1'b1.
  - direction constants DIR_UP and DIR_DOWN.
- Sub-module pwm_timebase: prescaler, up/down counter, direction, tick and boundary outputs.
- Top level: shadow registers plus a generate loop of per-channel compare flops.

Test Plan:
- Edge mode, WIDTH=8, prescale=0, P=9, duty0=3, en=1 -> out[0] high 3 of every 10 clk; sync every 10 clk; duty1=0 -> out[1] constant 0.
- Center mode, P=4, duty0=2 -> counter sequence 0,1,2,3,4,3,2,1; out[0] high 3 of 8 clk; sync period 8 clk.
- prescale=2, edge, P=9, duty0=5 -> tick every 3 clk; period 30 clk; out[0] high 15 clk.
- Shadowing: duty0 changed 3->7 five ticks into a period -> that period keeps 3 high ticks, next period 7; period changed 9->4 mid-period -> current period still 10 ticks.
- duty0=255 with P=9 -> out[0] constant 1, no low cycle at wrap; en deasserted -> out=0 next clk, counter 0.
- rst_n pulsed low for 1 clk mid-period -> out=0, sync=0 that edge; with en held high, counter restarts at 0 and sync pulses for the new first period (timing as in Behaviour).
